// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the single-port data memory, with bounded lock.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention; default build is fixed priority (port 0).
module dmem_arbiter #(
    parameter int ADDR     = 10,
    parameter int DATA     = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic            m0_lock,
    input  logic [ADDR-1:0] m0_addr,
    input  logic [DATA-1:0] m0_wdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic            m1_lock,
    input  logic [ADDR-1:0] m1_addr,
    input  logic [DATA-1:0] m1_wdata,
    output logic            m0_gnt,
    output logic            m1_gnt,
    output logic            m0_rvalid,
    output logic            m1_rvalid,
    output logic [DATA-1:0] m0_rdata,
    output logic [DATA-1:0] m1_rdata,
    output logic            mem_wr_en,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_d_in,
    input  logic [DATA-1:0] mem_d_out
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          r_state;
    logic            r_last;
    logic            r_owner;
    logic [CW-1:0]   r_lock_cnt;
    logic            r_rd_vld;
    logic            r_rd_port;

    logic w_forced;
    logic w_locked;
    logic w_pick;
    logic w_gnt0;
    logic w_gnt1;
    logic w_any;
    logic w_port;
    logic w_we;
    logic w_lock;

    // A saturated lock behaves like IDLE, but the non-owner wins contention.
    always_comb begin
        w_forced = (r_state == S_LOCKED) && (r_lock_cnt == CNT_MAX);
        w_locked = (r_state == S_LOCKED) && !w_forced;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        w_pick = w_forced ? ~r_owner : ~r_last;
`else
        w_pick = w_forced ? ~r_owner : 1'b0;
`endif
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (w_locked) begin
                w_gnt0 = !r_owner && m0_req;
                w_gnt1 = r_owner && m1_req;
            end else if (m0_req && m1_req) begin
                w_gnt0 = !w_pick;
                w_gnt1 = w_pick;
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
        w_any  = w_gnt0 || w_gnt1;
        w_port = w_gnt1;
        w_we   = w_port ? m1_we : m0_we;
        w_lock = w_port ? m1_lock : m0_lock;
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign mem_wr_en = w_any && w_we;
    assign mem_addr  = w_gnt1 ? m1_addr : m0_addr;
    assign mem_d_in  = w_gnt1 ? m1_wdata : m0_wdata;

    assign m0_rvalid = r_rd_vld && !r_rd_port;
    assign m1_rvalid = r_rd_vld && r_rd_port;
    assign m0_rdata  = m0_rvalid ? mem_d_out : '0;
    assign m1_rdata  = m1_rvalid ? mem_d_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_lock_cnt <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_port  <= 1'b0;
        end else begin
            if (w_any) begin
                r_last    <= w_port;
                r_rd_vld  <= !w_we;
                r_rd_port <= w_port;
            end else begin
                r_rd_vld  <= 1'b0;
            end
            if (w_locked) begin
                if (w_any && w_lock) begin
                    r_lock_cnt <= r_lock_cnt + CW'(1);
                end else begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= '0;
                end
            end else if (w_any && w_lock) begin
                r_state    <= S_LOCKED;
                r_owner    <= w_port;
                r_lock_cnt <= CW'(1);
            end else begin
                r_state    <= S_IDLE;
                r_lock_cnt <= '0;
            end
        end
    end

endmodule
